// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared write-back widths and buffered result record
package wb_pkg;

  localparam int OPRAND_WIDTH  = 32;
  localparam int REGNAME_WIDTH = 5;
  localparam int NUM_SRC       = 4;
  localparam int SRC_IDX_W     = $clog2(NUM_SRC);

  typedef struct packed {
    logic [REGNAME_WIDTH-1:0] addr;
    logic [OPRAND_WIDTH-1:0]  data;
  } wb_req_t;

endpackage

// File: rtl/wb_arbiter_4to2_if.sv
// rtl/wb_arbiter_4to2_if.sv - result sources and regfile write ports of the write-back arbiter
interface wb_arbiter_4to2_if;
  import wb_pkg::*;

  logic [NUM_SRC-1:0]                    src_valid_i;
  logic [NUM_SRC-1:0][REGNAME_WIDTH-1:0] src_addr_i;
  logic [NUM_SRC-1:0][OPRAND_WIDTH-1:0]  src_data_i;
  logic [NUM_SRC-1:0]                    src_ready_o;
  logic                                  write1_en_o;
  logic [REGNAME_WIDTH-1:0]              write1_addr_o;
  logic [OPRAND_WIDTH-1:0]               write1_data_o;
  logic                                  write2_en_o;
  logic [REGNAME_WIDTH-1:0]              write2_addr_o;
  logic [OPRAND_WIDTH-1:0]               write2_data_o;
  logic                                  busy_o;

  modport slave (
    input  src_valid_i, src_addr_i, src_data_i,
    output src_ready_o,
    output write1_en_o, write1_addr_o, write1_data_o,
    output write2_en_o, write2_addr_o, write2_data_o,
    output busy_o
  );

  modport master (
    output src_valid_i, src_addr_i, src_data_i,
    input  src_ready_o,
    input  write1_en_o, write1_addr_o, write1_data_o,
    input  write2_en_o, write2_addr_o, write2_data_o,
    input  busy_o
  );

endinterface

// File: rtl/rr_pick2.sv
// rtl/rr_pick2.sv - round-robin picker granting up to two entries with distinct addresses
module rr_pick2
  import wb_pkg::*;
(
  input  logic [NUM_SRC-1:0]                    valid_i,
  input  logic [NUM_SRC-1:0][REGNAME_WIDTH-1:0] addr_i,
  input  logic [SRC_IDX_W-1:0]                  rr_ptr_i,
  output logic                                  g1_v_o,
  output logic [SRC_IDX_W-1:0]                  g1_idx_o,
  output logic                                  g2_v_o,
  output logic [SRC_IDX_W-1:0]                  g2_idx_o,
  output logic [NUM_SRC-1:0]                    grant_o
);

  logic [SRC_IDX_W-1:0] idx;

  always_comb begin
    g1_v_o   = 1'b0;
    g1_idx_o = '0;
    g2_v_o   = 1'b0;
    g2_idx_o = '0;
    grant_o  = '0;
    idx      = '0;
    // NUM_SRC is a power of two, so the index add wraps naturally
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = rr_ptr_i + SRC_IDX_W'(k);
      if (valid_i[idx]) begin
        if (!g1_v_o) begin
          g1_v_o   = 1'b1;
          g1_idx_o = idx;
        end else if (!g2_v_o && (addr_i[idx] != addr_i[g1_idx_o])) begin
          g2_v_o   = 1'b1;
          g2_idx_o = idx;
        end
      end
    end
    if (g1_v_o) grant_o[g1_idx_o] = 1'b1;
    if (g2_v_o) grant_o[g2_idx_o] = 1'b1;
  end

endmodule

// File: rtl/wb_arbiter_4to2.sv
// rtl/wb_arbiter_4to2.sv - per-source result buffers feeding two registered regfile write ports
module wb_arbiter_4to2
  import wb_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  wb_arbiter_4to2_if.slave bus
);

  logic [NUM_SRC-1:0]                    buf_v_q, buf_v_d;
  wb_req_t [NUM_SRC-1:0]                 buf_q, buf_d;
  logic [NUM_SRC-1:0][REGNAME_WIDTH-1:0] buf_addr;
  logic [SRC_IDX_W-1:0]                  rr_ptr_q, rr_ptr_d;
  logic                                  w1_en_q, w1_en_d, w2_en_q, w2_en_d;
  wb_req_t                               w1_q, w1_d, w2_q, w2_d;
  logic                                  g1_v, g2_v;
  logic [SRC_IDX_W-1:0]                  g1_idx, g2_idx;
  logic [NUM_SRC-1:0]                    grant, ready, accept;

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) buf_addr[i] = buf_q[i].addr;
  end

  rr_pick2 u_pick (
    .valid_i  (buf_v_q),
    .addr_i   (buf_addr),
    .rr_ptr_i (rr_ptr_q),
    .g1_v_o   (g1_v),
    .g1_idx_o (g1_idx),
    .g2_v_o   (g2_v),
    .g2_idx_o (g2_idx),
    .grant_o  (grant)
  );

  // A granted buffer drains at this edge, so it can take a new result at the same edge
  assign ready  = ~buf_v_q | grant;
  assign accept = bus.src_valid_i & ready;

  always_comb begin
    buf_v_d = (buf_v_q & ~grant) | accept;
    buf_d   = buf_q;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (accept[i]) begin
        buf_d[i].addr = bus.src_addr_i[i];
        buf_d[i].data = bus.src_data_i[i];
      end
    end
    w1_en_d = g1_v;
    w1_d    = g1_v ? buf_q[g1_idx] : w1_q;
    w2_en_d = g2_v;
    w2_d    = g2_v ? buf_q[g2_idx] : w2_q;
    rr_ptr_d = rr_ptr_q;
    if (g2_v)      rr_ptr_d = g2_idx + SRC_IDX_W'(1);
    else if (g1_v) rr_ptr_d = g1_idx + SRC_IDX_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_v_q  <= '0;
      buf_q    <= '0;
      rr_ptr_q <= '0;
      w1_en_q  <= 1'b0;
      w1_q     <= '0;
      w2_en_q  <= 1'b0;
      w2_q     <= '0;
    end else begin
      buf_v_q  <= buf_v_d;
      buf_q    <= buf_d;
      rr_ptr_q <= rr_ptr_d;
      w1_en_q  <= w1_en_d;
      w1_q     <= w1_d;
      w2_en_q  <= w2_en_d;
      w2_q     <= w2_d;
    end
  end

  assign bus.src_ready_o   = ready;
  assign bus.write1_en_o   = w1_en_q;
  assign bus.write1_addr_o = w1_q.addr;
  assign bus.write1_data_o = w1_q.data;
  assign bus.write2_en_o   = w2_en_q;
  assign bus.write2_addr_o = w2_q.addr;
  assign bus.write2_data_o = w2_q.data;
  assign bus.busy_o        = (|buf_v_q) | w1_en_q | w2_en_q;

endmodule

// File: tb/tb_wb_arbiter_4to2.sv
// tb/tb_wb_arbiter_4to2.sv - vector table plus write scoreboard for wb_arbiter_4to2
module tb_wb_arbiter_4to2;
  import wb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_arbiter_4to2_if bus ();

  wb_arbiter_4to2 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct packed {
    logic        en1;
    logic [4:0]  a1;
    logic [31:0] d1;
    logic        en2;
    logic [4:0]  a2;
    logic [31:0] d2;
  } wr_t;

  // p1/p2[c]: source expected on port 1/2 in the c-th write cycle, 7 = no write
  typedef struct packed {
    logic [3:0]      valid;
    logic [3:0][4:0] addr;
    logic [2:0]      ncyc;
    logic [3:0][2:0] p1;
    logic [3:0][2:0] p2;
  } vec_t;

  localparam logic [2:0] NONE = 3'd7;

  wr_t  exp_q[$];
  vec_t vecs[7];
  vec_t v_rr;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  function automatic logic [31:0] dat(input int vid, input int s);
    return 32'hD000_0000 + 32'(vid * 256 + s);
  endfunction

  task automatic idle_inputs();
    bus.src_valid_i = '0;
    bus.src_addr_i  = '0;
    bus.src_data_i  = '0;
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic monitor_loop();
    wr_t e;
    bit  ok;
    forever begin
      @(negedge clk);
      if (bus.write1_en_o || bus.write2_en_o) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write got en1=%0b a1=%0d en2=%0b a2=%0d want no write",
                   bus.write1_en_o, bus.write1_addr_o, bus.write2_en_o, bus.write2_addr_o);
        end else begin
          e  = exp_q.pop_front();
          ok = (bus.write1_en_o == e.en1) && (bus.write2_en_o == e.en2) &&
               (!e.en1 || (bus.write1_addr_o == e.a1 && bus.write1_data_o == e.d1)) &&
               (!e.en2 || (bus.write2_addr_o == e.a2 && bus.write2_data_o == e.d2));
          if (!ok) begin
            errors++;
            $display("FAIL write_ports got en1=%0b a1=%0d d1=%h en2=%0b a2=%0d d2=%h want en1=%0b a1=%0d d1=%h en2=%0b a2=%0d d2=%h",
                     bus.write1_en_o, bus.write1_addr_o, bus.write1_data_o,
                     bus.write2_en_o, bus.write2_addr_o, bus.write2_data_o,
                     e.en1, e.a1, e.d1, e.en2, e.a2, e.d2);
          end
        end
      end
    end
  endtask

  task automatic run_vec(input vec_t v, input int vid);
    wr_t e;
    @(negedge clk);
    for (int s = 0; s < 4; s++) begin
      bus.src_addr_i[s] = v.addr[s];
      bus.src_data_i[s] = dat(vid, s);
    end
    bus.src_valid_i = v.valid;
    for (int c = 0; c < int'(v.ncyc); c++) begin
      e = '0;
      if (v.p1[c] != NONE) begin
        e.en1 = 1'b1;
        e.a1  = v.addr[v.p1[c]];
        e.d1  = dat(vid, int'(v.p1[c]));
      end
      if (v.p2[c] != NONE) begin
        e.en2 = 1'b1;
        e.a2  = v.addr[v.p2[c]];
        e.d2  = dat(vid, int'(v.p2[c]));
      end
      exp_q.push_back(e);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_pending"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    chk({name, "_busy_idle"}, 64'(bus.busy_o), 64'd0);
  endtask

  initial begin
    wr_t e;
    vecs[0] = '{4'b1111, {5'd4, 5'd3, 5'd2, 5'd1},  3'd2, {NONE, NONE, 3'd2, 3'd0}, {NONE, NONE, 3'd3, 3'd1}};
    vecs[1] = '{4'b0111, {5'd0, 5'd9, 5'd7, 5'd7},  3'd2, {NONE, NONE, 3'd1, 3'd0}, {NONE, NONE, NONE, 3'd2}};
    vecs[2] = '{4'b1010, {5'd9, 5'd0, 5'd8, 5'd0},  3'd1, {NONE, NONE, NONE, 3'd1}, {NONE, NONE, NONE, 3'd3}};
    vecs[3] = '{4'b1111, {5'd6, 5'd6, 5'd6, 5'd6},  3'd4, {3'd3, 3'd2, 3'd1, 3'd0}, {NONE, NONE, NONE, NONE}};
    vecs[4] = '{4'b0100, {5'd0, 5'd0, 5'd0, 5'd0},  3'd1, {NONE, NONE, NONE, 3'd2}, {NONE, NONE, NONE, NONE}};
    vecs[5] = '{4'b1111, {5'd4, 5'd4, 5'd3, 5'd3},  3'd2, {NONE, NONE, 3'd3, 3'd0}, {NONE, NONE, 3'd1, 3'd2}};
    vecs[6] = '{4'b0011, {5'd0, 5'd0, 5'd0, 5'd31}, 3'd1, {NONE, NONE, NONE, 3'd0}, {NONE, NONE, NONE, 3'd1}};
    v_rr    = '{4'b1001, {5'd21, 5'd0, 5'd0, 5'd20}, 3'd1, {NONE, NONE, NONE, 3'd0}, {NONE, NONE, NONE, 3'd3}};

    fork
      monitor_loop();
    join_none

    // reset held with every source offering
    rst = 1'b1;
    bus.src_valid_i = 4'b1111;
    bus.src_addr_i  = {5'd4, 5'd3, 5'd2, 5'd1};
    bus.src_data_i  = {32'h44, 32'h33, 32'h22, 32'h11};
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst_w1_en", 64'(bus.write1_en_o), 64'd0);
      chk("rst_w2_en", 64'(bus.write2_en_o), 64'd0);
      chk("rst_busy", 64'(bus.busy_o), 64'd0);
      chk("rst_ready", 64'(bus.src_ready_o), 64'hf);
    end
    chk("rst_w1_addr", 64'(bus.write1_addr_o), 64'd0);
    chk("rst_w1_data", 64'(bus.write1_data_o), 64'd0);
    rst = 1'b0;
    idle_inputs();
    repeat (4) @(negedge clk);
    chk("rst_release_busy", 64'(bus.busy_o), 64'd0);

    // single result: two edges from acceptance to valid port outputs
    do_reset(2);
    @(negedge clk);
    bus.src_valid_i   = 4'b0001;
    bus.src_addr_i[0] = 5'd5;
    bus.src_data_i[0] = 32'hDEADBEEF;
    e = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0};
    exp_q.push_back(e);
    @(negedge clk);
    idle_inputs();
    chk("single_lat1_w1_en", 64'(bus.write1_en_o), 64'd0);
    chk("single_lat1_busy", 64'(bus.busy_o), 64'd1);
    @(negedge clk);
    chk("single_lat2_w1_en", 64'(bus.write1_en_o), 64'd1);
    chk("single_lat2_w2_en", 64'(bus.write2_en_o), 64'd0);
    drain("single");

    for (int i = 0; i < 7; i++) begin
      do_reset(2);
      run_vec(vecs[i], i);
      drain($sformatf("vec%0d", i));
    end

    // after 1/2/3/4 the pointer is back at 0, so src0 leads src3
    do_reset(2);
    run_vec(vecs[0], 20);
    drain("rr_first");
    run_vec(v_rr, 21);
    drain("rr_wrap");

    // src3 streams one result per cycle
    do_reset(2);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k < 4) begin
        bus.src_valid_i   = 4'b1000;
        bus.src_addr_i[3] = 5'(10 + k);
        bus.src_data_i[3] = 32'h5000_0000 + 32'(k);
        e = '{1'b1, 5'(10 + k), 32'h5000_0000 + 32'(k), 1'b0, 5'd0, 32'd0};
        exp_q.push_back(e);
      end else begin
        idle_inputs();
      end
      #1;
      if (k < 4) chk($sformatf("stream_ready_%0d", k), 64'(bus.src_ready_o[3]), 64'd1);
      if (k >= 2) begin
        chk($sformatf("stream_w1_en_%0d", k), 64'(bus.write1_en_o), 64'd1);
        chk($sformatf("stream_w2_en_%0d", k), 64'(bus.write2_en_o), 64'd0);
      end
    end
    drain("stream");

    // reset while three buffers hold results
    do_reset(2);
    @(negedge clk);
    bus.src_valid_i = 4'b0111;
    bus.src_addr_i  = {5'd6, 5'd6, 5'd6, 5'd6};
    bus.src_data_i  = {32'h4, 32'h3, 32'h2, 32'h1};
    @(negedge clk);
    #1;
    chk("midrst_busy_before", 64'(bus.busy_o), 64'd1);
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    chk("midrst_busy", 64'(bus.busy_o), 64'd0);
    chk("midrst_w1_en", 64'(bus.write1_en_o), 64'd0);
    chk("midrst_w2_en", 64'(bus.write2_en_o), 64'd0);
    chk("midrst_w1_addr", 64'(bus.write1_addr_o), 64'd0);
    chk("midrst_w1_data", 64'(bus.write1_data_o), 64'd0);
    chk("midrst_ready", 64'(bus.src_ready_o), 64'hf);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("midrst_after_busy", 64'(bus.busy_o), 64'd0);

    repeat (2) @(negedge clk);
    chk("final_queue", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
